// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
//   Handshake bundle between the mul/div sequencer and the multi-cycle
//   mul/div unit.
//   master (sequencer): drives unit_start, unit_func, unit_sign, unit_a,
//                       unit_b, unit_cancel; receives unit_done, unit_hi,
//                       unit_lo.
//   slave  (unit):      the mirror image.
// Parameters: DATA_W operand/result width, FUNC_W func code width.
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FUNC_W = 5
);
  logic              unit_start;
  logic [FUNC_W-1:0] unit_func;
  logic              unit_sign;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              unit_cancel;
  logic              unit_done;
  logic [DATA_W-1:0] unit_hi;
  logic [DATA_W-1:0] unit_lo;

  modport master (
    output unit_start, unit_func, unit_sign, unit_a, unit_b, unit_cancel,
    input  unit_done, unit_hi, unit_lo
  );

  modport slave (
    input  unit_start, unit_func, unit_sign, unit_a, unit_b, unit_cancel,
    output unit_done, unit_hi, unit_lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer between the EX-stage ALU and the multi-cycle mul/div unit.
//   Latches a MUL/DIV request, issues a one-cycle start, stalls the pipeline
//   while the unit runs, captures HI/LO and commits them only when the
//   instruction leaves EX unflushed. A start->done timeout aborts a hung unit.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req_func/sign/a/b   EX-stage request (only FUNC_MUL / FUNC_DIV start work)
//   pipe_adv            EX instruction advances this cycle
//   flush               kill EX instruction
//   unit (master)       start/func/sign/a/b/cancel out, done/hi/lo in
//   stall               hold IF/ID/EX (combinational in the accept cycle)
//   hi_write, lo_write  HI/LO write enables, asserted together for one cycle
//                       in the cycle after the instruction advanced
//   hi_wdata, lo_wdata  committed HI/LO values
//   err_timeout         sticky timeout flag, cleared only by reset
//
// Build option
//   MULDIV_FAST_ZERO_EN : a zero operand completes without the unit, result 0.
//
// Latency: a unit answering L cycles after start (L=1 means done in the
// start cycle) stalls the pipeline for L+1 cycles including the accept cycle.
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       FUNC_W      = 5,
  parameter logic [FUNC_W-1:0] FUNC_MUL    = FUNC_W'(24),
  parameter logic [FUNC_W-1:0] FUNC_DIV    = FUNC_W'(26),
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FUNC_W-1:0] req_func,
  input  logic              req_sign,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              pipe_adv,
  input  logic              flush,
  muldiv_ctrl_if.master     unit,
  output logic              stall,
  output logic              hi_write,
  output logic              lo_write,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_cap;
  logic [DATA_W-1:0] lo_cap;

  logic is_md;
  logic accept;
  logic timeout;
  logic zero_op;

  // Accept, stall and cancel are combinational so the pipeline freezes and
  // the unit aborts in the very cycle the condition is seen. All three are
  // gated by rst_n so that nothing leaks out while reset is held.
  always_comb begin
    is_md            = (req_func == FUNC_MUL) || (req_func == FUNC_DIV);
    accept           = rst_n && (state == S_IDLE) && is_md && !flush;
    timeout          = (state == S_BUSY) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    // done beats both flush-cancel and timeout-cancel
    unit.unit_cancel = rst_n && (state == S_BUSY) && !unit.unit_done &&
                       (flush || timeout);
    stall            = accept || (rst_n && (state == S_BUSY));
`ifdef MULDIV_FAST_ZERO_EN
    // Any zero operand yields hi=lo=0 for MUL and DIV alike.
    zero_op          = (req_a == '0) || (req_b == '0);
`else
    zero_op          = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      hi_cap         <= '0;
      lo_cap         <= '0;
      unit.unit_start <= 1'b0;
      unit.unit_func <= '0;
      unit.unit_sign <= 1'b0;
      unit.unit_a    <= '0;
      unit.unit_b    <= '0;
      hi_write       <= 1'b0;
      lo_write       <= 1'b0;
      hi_wdata       <= '0;
      lo_wdata       <= '0;
      err_timeout    <= 1'b0;
    end else begin
      unit.unit_start <= 1'b0;
      hi_write        <= 1'b0;
      lo_write        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unit.unit_func <= req_func;
            unit.unit_sign <= req_sign;
            unit.unit_a    <= req_a;
            unit.unit_b    <= req_b;
            if (zero_op) begin
              hi_cap <= '0;
              lo_cap <= '0;
              state  <= S_DONE;
            end else begin
              unit.unit_start <= 1'b1;
              cnt             <= '0;
              state           <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // Priority: flush > done > timeout.
          if (flush) begin
            state <= S_IDLE;
          end else if (unit.unit_done) begin
            hi_cap <= unit.unit_hi;
            lo_cap <= unit.unit_lo;
            state  <= S_DONE;
          end else if (timeout) begin
            hi_cap      <= '0;
            lo_cap      <= '0;
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (pipe_adv) begin
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            hi_wdata <= hi_cap;
            lo_wdata <= lo_cap;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl. Inputs change just after the falling
//   edge; outputs are examined 1 time unit later, clear of the rising edge.
//   The mul/div unit is played by the bench: unit_done/hi/lo are driven by
//   hand in the cycles listed below. Cycle k=0 is the accept cycle, k=1 the
//   start cycle.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned FW    = 5;
  localparam logic [4:0]  F_MUL = 5'h18;
  localparam logic [4:0]  F_DIV = 5'h1A;
  localparam logic [4:0]  F_ADD = 5'h00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] req_func;
  logic          req_sign;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          pipe_adv;
  logic          flush;
  logic          stall;
  logic          hi_write;
  logic          lo_write;
  logic [DW-1:0] hi_wdata;
  logic [DW-1:0] lo_wdata;
  logic          err_timeout;

  int n_vec = 0;
  int n_err = 0;
  int stalls;
  int starts;

  muldiv_ctrl_if #(.DATA_W(DW), .FUNC_W(FW)) u ();

  muldiv_ctrl #(
    .DATA_W     (DW),
    .FUNC_W     (FW),
    .FUNC_MUL   (F_MUL),
    .FUNC_DIV   (F_DIV),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_func   (req_func),
    .req_sign   (req_sign),
    .req_a      (req_a),
    .req_b      (req_b),
    .pipe_adv   (pipe_adv),
    .flush      (flush),
    .unit       (u.master),
    .stall      (stall),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle with single-cycle inputs deasserted.
  task automatic nxt();
    @(negedge clk);
    u.unit_done = 1'b0;
    u.unit_hi   = '0;
    u.unit_lo   = '0;
    flush       = 1'b0;
    pipe_adv    = 1'b0;
  endtask

  task automatic req(input logic [4:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
    req_func = f;
    req_sign = s;
    req_a    = a;
    req_b    = b;
  endtask

  initial begin
    rst_n = 1'b0;
    req(F_MUL, 1'b0, 32'd1, 32'd1);
    pipe_adv = 1'b0; flush = 1'b0;
    u.unit_done = 1'b0; u.unit_hi = '0; u.unit_lo = '0;

    // ---- reset: outputs quiet even with a MUL presented ----
    nxt(); nxt(); #1;
    chk("rst_stall", stall, 0);
    chk("rst_start", u.unit_start, 0);
    chk("rst_cancel", u.unit_cancel, 0);
    chk("rst_hi_write", hi_write, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_unit_a", u.unit_a, 0);
    chk("rst_hi_wdata", hi_wdata, 0);

    // ---- MUL signed -3*5, unit latency 1 ----
    nxt(); rst_n = 1'b1; req(F_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5); #1;
    chk("mul_accept_stall", stall, 1);
    chk("mul_accept_nostart", u.unit_start, 0);
    nxt(); u.unit_done = 1'b1; u.unit_hi = 32'hFFFF_FFFF; u.unit_lo = 32'hFFFF_FFF1; #1;
    chk("mul_start", u.unit_start, 1);
    chk("mul_busy_stall", stall, 1);
    chk("mul_unit_a", u.unit_a, 32'hFFFF_FFFD);
    chk("mul_unit_b", u.unit_b, 32'd5);
    chk("mul_unit_sign", u.unit_sign, 1);
    chk("mul_unit_func", u.unit_func, F_MUL);
    nxt(); pipe_adv = 1'b1; #1;
    chk("mul_done_nostall", stall, 0);
    chk("mul_single_start", u.unit_start, 0);
    chk("mul_done_nowrite_yet", hi_write, 0);
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); pipe_adv = 1'b1; #1;
    chk("mul_hi_write", hi_write, 1);
    chk("mul_lo_write", lo_write, 1);
    chk("mul_hi", hi_wdata, 32'hFFFF_FFFF);
    chk("mul_lo", lo_wdata, 32'hFFFF_FFF1);
    nxt(); #1;
    chk("mul_write_once", hi_write, 0);

    // ---- DIV unsigned 100/7, latency 33, pipe held 3 cycles ----
    nxt(); req(F_DIV, 1'b0, 32'd100, 32'd7); #1;
    stalls = stall ? 1 : 0;
    starts = u.unit_start ? 1 : 0;
    for (int k = 1; k <= 33; k++) begin
      nxt();
      if (k == 33) begin
        u.unit_done = 1'b1; u.unit_hi = 32'd2; u.unit_lo = 32'd14;
      end
      #1;
      stalls += stall ? 1 : 0;
      starts += u.unit_start ? 1 : 0;
      if (k == 33) chk("div_a_stable", u.unit_a, 32'd100);
    end
    for (int k = 34; k <= 36; k++) begin
      nxt(); #1;
      stalls += stall ? 1 : 0;
      chk("div_hold_nowrite", hi_write, 0);
    end
    nxt(); pipe_adv = 1'b1; #1;
    stalls += stall ? 1 : 0;
    chk("div_stall_cycles", stalls, 34);
    chk("div_start_count", starts, 1);
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); pipe_adv = 1'b1; #1;
    chk("div_write", hi_write, 1);
    chk("div_hi", hi_wdata, 32'd2);
    chk("div_lo", lo_wdata, 32'd14);

    // ---- flush during DIV on cycle 5, then a clean MUL ----
    nxt(); req(F_DIV, 1'b0, 32'd50, 32'd3); #1;
    for (int k = 1; k <= 4; k++) begin
      nxt(); #1;
      chk("flush_busy_nocancel", u.unit_cancel, 0);
    end
    nxt(); flush = 1'b1; #1;
    chk("flush_cancel", u.unit_cancel, 1);
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); #1;
    chk("flush_nostall", stall, 0);
    chk("flush_cancel_once", u.unit_cancel, 0);
    nxt(); #1;
    chk("flush_nowrite", hi_write, 0);
    nxt(); req(F_MUL, 1'b0, 32'd6, 32'd7); #1;
    chk("post_flush_accept", stall, 1);
    nxt(); u.unit_done = 1'b1; u.unit_hi = 32'd0; u.unit_lo = 32'd42; #1;
    chk("post_flush_start", u.unit_start, 1);
    nxt(); pipe_adv = 1'b1; #1;
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); #1;
    chk("post_flush_write", hi_write, 1);
    chk("post_flush_lo", lo_wdata, 32'd42);

    // ---- timeout: unit never answers ----
    nxt(); req(F_MUL, 1'b0, 32'd2, 32'd3); #1;
    starts = 0;
    for (int k = 1; k <= 64; k++) begin
      nxt(); #1;
      starts += u.unit_start ? 1 : 0;
      if (k == 63) chk("to_no_early_cancel", u.unit_cancel, 0);
      if (k == 64) begin
        chk("to_cancel", u.unit_cancel, 1);
        chk("to_err_not_yet", err_timeout, 0);
      end
    end
    nxt(); pipe_adv = 1'b1; #1;
    chk("to_err", err_timeout, 1);
    chk("to_nostall", stall, 0);
    chk("to_cancel_once", u.unit_cancel, 0);
    chk("to_start_count", starts, 1);
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); #1;
    chk("to_write", hi_write, 1);
    chk("to_hi_zero", hi_wdata, 0);
    chk("to_lo_zero", lo_wdata, 0);
    nxt(); #1;
    chk("to_err_sticky", err_timeout, 1);

    // ---- done and flush together: flush wins, no cancel ----
    nxt(); req(F_MUL, 1'b0, 32'd4, 32'd4); #1;
    nxt(); #1;
    nxt(); u.unit_done = 1'b1; u.unit_lo = 32'd16; flush = 1'b1; #1;
    chk("doneflush_nocancel", u.unit_cancel, 0);
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); pipe_adv = 1'b1; #1;
    chk("doneflush_idle", stall, 0);
    nxt(); #1;
    chk("doneflush_nowrite", hi_write, 0);

    // ---- reset in BUSY ----
    nxt(); req(F_MUL, 1'b0, 32'd5, 32'd5); #1;
    nxt(); #1;
    nxt(); rst_n = 1'b0; #1;
    chk("rstbusy_nocancel", u.unit_cancel, 0);
    chk("rstbusy_nostall", stall, 0);
    nxt(); rst_n = 1'b1; req(F_ADD, 1'b0, 32'd0, 32'd0); #1;
    chk("rstbusy_start", u.unit_start, 0);
    chk("rstbusy_stall", stall, 0);
    chk("rstbusy_write", hi_write, 0);
    chk("rstbusy_unit_a", u.unit_a, 0);
    chk("rstbusy_hi_wdata", hi_wdata, 0);
    chk("rstbusy_err_cleared", err_timeout, 0);

    // ---- done on the timeout cycle: done wins, no error ----
    nxt(); req(F_DIV, 1'b1, 32'd9, 32'd2); #1;
    for (int k = 1; k <= 64; k++) begin
      nxt();
      if (k == 64) begin
        u.unit_done = 1'b1; u.unit_hi = 32'd1; u.unit_lo = 32'd4;
      end
      #1;
      if (k == 64) chk("donetime_nocancel", u.unit_cancel, 0);
    end
    nxt(); pipe_adv = 1'b1; #1;
    chk("donetime_noerr", err_timeout, 0);
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); #1;
    chk("donetime_hi", hi_wdata, 32'd1);
    chk("donetime_lo", lo_wdata, 32'd4);

    // ---- zero operand MUL 0*9 ----
    nxt(); req(F_MUL, 1'b0, 32'd0, 32'd9); #1;
    chk("zero_accept_stall", stall, 1);
`ifdef MULDIV_FAST_ZERO_EN
    nxt(); pipe_adv = 1'b1; #1;
    chk("zero_nostart", u.unit_start, 0);
    chk("zero_stall_one", stall, 0);
`else
    nxt(); u.unit_done = 1'b1; #1;
    chk("zero_start", u.unit_start, 1);
    chk("zero_busy_stall", stall, 1);
    nxt(); pipe_adv = 1'b1; #1;
`endif
    nxt(); req(F_ADD, 1'b0, 32'd0, 32'd0); #1;
    chk("zero_write", hi_write, 1);
    chk("zero_hi", hi_wdata, 0);
    chk("zero_lo", lo_wdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
